// File: rtl/jt51_phacc.sv
// jt51_phacc: JT51 phase generator.
// Converts the per-slot extended key code into a phase increment. The
// increment is built by table interpolation, octave shift, optional DT1
// detune and MUL scaling. A 20-bit phase is then accumulated per operator
// slot in a 32-entry ring.
// Optional feature: define JT51_PG_DT1_EN to enable the DT1 detune path.
// Pipeline: stage 1 (decode/interp), stage 2 (octave/DT1), stage 3a (MUL),
// stage 3b (accumulate). A slot sampled on cen edge N appears on cen edge N+3.

module jt51_phacc (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [12:0] kcex,
    input  logic [2:0]  dt1,
    input  logic [3:0]  mul,
    input  logic        keyon,
    output logic [9:0]  phase,
    output logic [4:0]  slot_out
);

    // Base increments for the 12 semitones, plus the next octave's first note
    // so that interpolation at note 11 has an upper neighbour.
    function automatic logic [11:0] base_tab(input logic [3:0] idx);
        logic [11:0] val;
        case (idx)
            4'd0:    val = 12'd1299;
            4'd1:    val = 12'd1376;
            4'd2:    val = 12'd1458;
            4'd3:    val = 12'd1545;
            4'd4:    val = 12'd1637;
            4'd5:    val = 12'd1734;
            4'd6:    val = 12'd1837;
            4'd7:    val = 12'd1946;
            4'd8:    val = 12'd2062;
            4'd9:    val = 12'd2185;
            4'd10:   val = 12'd2315;
            4'd11:   val = 12'd2452;
            default: val = 12'd2598;
        endcase
        return val;
    endfunction

    logic [4:0]  slot_in;

    // stage 1 registers
    logic [11:0] inc1;
    logic [2:0]  oct1;
    logic [3:0]  mul1;
    logic        keyon1;
    logic [4:0]  slot1;

    // stage 2 registers
    logic [16:0] pdt2;
    logic [3:0]  mul2;
    logic        keyon2;
    logic [4:0]  slot2;

    // stage 3 registers
    logic [19:0] minc3;
    logic        keyon3;
    logic [4:0]  slot3;

    logic [19:0] ring [0:31];

    // stage 1 combinational
    logic [3:0]  note;
    logic [3:0]  n_lo;
    logic [3:0]  n_hi;
    logic [11:0] b_lo;
    logic [11:0] b_hi;
    logic [11:0] diff;
    logic [17:0] interp;
    logic [11:0] interp_sh;
    logic [11:0] inc_s1;

    // stage 2 combinational
    logic [18:0] shifted;
    logic [16:0] pinc;
    logic [16:0] pdt_s2;

    // stage 3 combinational
    logic [19:0] minc_s3;
    logic [19:0] old_ph;
    logic [19:0] new_ph;

`ifdef JT51_PG_DT1_EN
    logic [2:0]  dt1_1;
    logic [4:0]  det;
`else
    logic        unused_dt1;
    assign unused_dt1 = ^dt1;
`endif

    // Stage 1: fold notes 3/7/11/15 onto the next note, then interpolate by kf.
    always_comb begin
        note      = kcex[9:6];
        n_lo      = note - {2'b00, note[3:2]};
        n_hi      = n_lo + 4'd1;
        b_lo      = base_tab(n_lo);
        b_hi      = base_tab(n_hi);
        diff      = b_hi - b_lo;
        interp    = 18'(diff) * 18'(kcex[5:0]);
        interp_sh = 12'(interp >> 6);
        inc_s1    = b_lo + interp_sh;
    end

    // Stage 2: octave shift and optional signed detune, wrapping at 17 bits.
    always_comb begin
        shifted = {7'd0, inc1} << oct1;
        pinc    = 17'(shifted >> 2);
`ifdef JT51_PG_DT1_EN
        det     = 5'(dt1_1[1:0]) * (5'(oct1) + 5'd1);
        pdt_s2  = dt1_1[2] ? (pinc - 17'(det)) : (pinc + 17'(det));
`else
        pdt_s2  = pinc;
`endif
    end

    // Stage 3: MUL scaling (0 means half) and keyon-aware accumulation.
    always_comb begin
        if (mul2 == 4'd0)
            minc_s3 = 20'(pdt2 >> 1);
        else
            minc_s3 = 20'(pdt2) * 20'(mul2);
        old_ph = ring[slot3];
        new_ph = keyon3 ? 20'd0 : (old_ph + minc3);
    end

    // Slot counter and pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_in <= 5'd0;
            inc1    <= 12'd0;
            oct1    <= 3'd0;
            mul1    <= 4'd0;
            keyon1  <= 1'b0;
            slot1   <= 5'd0;
            pdt2    <= 17'd0;
            mul2    <= 4'd0;
            keyon2  <= 1'b0;
            slot2   <= 5'd0;
            minc3   <= 20'd0;
            keyon3  <= 1'b0;
            slot3   <= 5'd0;
`ifdef JT51_PG_DT1_EN
            dt1_1   <= 3'd0;
`endif
        end else if (cen) begin
            slot_in <= slot_in + 5'd1;
            inc1    <= inc_s1;
            oct1    <= kcex[12:10];
            mul1    <= mul;
            keyon1  <= keyon;
            slot1   <= slot_in;
            pdt2    <= pdt_s2;
            mul2    <= mul1;
            keyon2  <= keyon1;
            slot2   <= slot1;
            minc3   <= minc_s3;
            keyon3  <= keyon2;
            slot3   <= slot2;
`ifdef JT51_PG_DT1_EN
            dt1_1   <= dt1;
`endif
        end
    end

    // Phase ring write-back and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) ring[i] <= 20'd0;
            phase    <= 10'd0;
            slot_out <= 5'd0;
        end else if (cen) begin
            ring[slot3] <= new_ph;
            phase       <= new_ph[19:10];
            slot_out    <= slot3;
        end
    end

endmodule

// File: tb/tb_jt51_phacc.sv
// Testbench for jt51_phacc. Stimulus pushes expected (slot, phase) pairs
// into a queue; a monitor pops them three cen edges later and compares.
module tb_jt51_phacc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic [12:0] kcex = 13'd0;
    logic [2:0]  dt1 = 3'd0;
    logic [3:0]  mul = 4'd1;
    logic        keyon = 1'b0;
    logic [9:0]  phase;
    logic [4:0]  slot_out;

    jt51_phacc dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .kcex     (kcex),
        .dt1      (dt1),
        .mul      (mul),
        .keyon    (keyon),
        .phase    (phase),
        .slot_out (slot_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] s;
        logic [9:0] p;
    } exp_t;

    exp_t        q[$];
    exp_t        last_exp = '0;
    exp_t        mon_e;
    logic [19:0] acc [32];
    int          sl = 0;
    int          total = 0;
    int          bad = 0;

`ifdef JT51_PG_DT1_EN
    localparam int DET_INC = 1290;
`else
    localparam int DET_INC = 1299;
`endif

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: after every cen edge, pop one expectation once the pipeline is full.
    initial begin
        forever begin
            @(posedge clk);
            if (cen && !rst) begin
                #1;
                if (q.size() > 3) begin
                    mon_e = q.pop_front();
                    check("sb_slot", int'(slot_out), int'(mon_e.s));
                    check("sb_phase", int'(phase), int'(mon_e.p));
                    last_exp = mon_e;
                end else begin
                    check("fill_slot", int'(slot_out), 0);
                    check("fill_phase", int'(phase), 0);
                    last_exp = '0;
                end
            end
        end
    end

    task automatic do_reset(input logic with_cen);
        @(negedge clk);
        rst   = 1'b1;
        cen   = with_cen;
        keyon = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cen = 1'b0;
        q.delete();
        for (int i = 0; i < 32; i++) acc[i] = 20'd0;
        sl = 0;
        last_exp = '0;
        check("rst_phase", int'(phase), 0);
        check("rst_slot", int'(slot_out), 0);
    endtask

    // Drive nsteps slots; inc is the hand-computed per-frame increment.
    task automatic run(input int nsteps, input logic [12:0] k, input logic [2:0] d,
                       input logic [3:0] m, input logic [19:0] inc,
                       input int ko_frame, input int ko_slot);
        for (int i = 0; i < nsteps; i++) begin
            logic ko;
            @(negedge clk);
            ko    = ((i / 32) == ko_frame) && (sl == ko_slot);
            cen   = 1'b1;
            kcex  = k;
            dt1   = d;
            mul   = m;
            keyon = ko;
            if (ko) acc[sl] = 20'd0;
            else    acc[sl] = acc[sl] + inc;
            q.push_back({5'(sl), acc[sl][19:10]});
            sl = (sl + 1) % 32;
        end
    endtask

    task automatic stall(input int nclk);
        @(negedge clk);
        cen = 1'b0;
        repeat (nclk) begin
            @(posedge clk);
            #1;
            check("stall_phase", int'(phase), int'(last_exp.p));
            check("stall_slot", int'(slot_out), int'(last_exp.s));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        do_reset(1'b0);

        // base note: inc 1299, minc 324, phase 1 in frame 4
        run(128, 13'd0, 3'd0, 4'd1, 20'd324, -1, -1);

        // octave 4, mul 2: 10392 per frame, wraps in frame 101
        do_reset(1'b1);
        run(101 * 32, {3'd4, 4'd0, 6'd0}, 3'd0, 4'd2, 20'd10392, -1, -1);

        // interpolation kf=32: 1337
        do_reset(1'b1);
        run(96, {3'd2, 4'd0, 6'd32}, 3'd0, 4'd1, 20'd1337, -1, -1);

        // note 3 aliases to note 4: both 1545
        do_reset(1'b1);
        run(64, {3'd2, 4'd3, 6'd0}, 3'd0, 4'd1, 20'd1545, -1, -1);
        do_reset(1'b1);
        run(64, {3'd2, 4'd4, 6'd0}, 3'd0, 4'd1, 20'd1545, -1, -1);

        // detune -3 at octave 2
        do_reset(1'b1);
        run(64, {3'd2, 4'd0, 6'd0}, 3'b111, 4'd1, 20'(DET_INC), -1, -1);

        // mul 0 halves: 649
        do_reset(1'b1);
        run(64, {3'd2, 4'd0, 6'd0}, 3'd0, 4'd0, 20'd649, -1, -1);

        // keyon on slot 5 in the second frame only
        do_reset(1'b1);
        run(96, {3'd4, 4'd0, 6'd0}, 3'd0, 4'd2, 20'd10392, 1, 5);

        // cen gating mid-frame
        do_reset(1'b1);
        run(45, {3'd4, 4'd0, 6'd0}, 3'd0, 4'd2, 20'd10392, -1, -1);
        stall(10);
        run(40, {3'd4, 4'd0, 6'd0}, 3'd0, 4'd2, 20'd10392, -1, -1);

        // reset mid-frame, then restart from slot 0 with zeroed ring
        do_reset(1'b1);
        run(70, {3'd4, 4'd0, 6'd0}, 3'd0, 4'd2, 20'd10392, -1, -1);

        @(negedge clk);
        cen = 1'b0;
        @(negedge clk);
        check("in_flight_left", q.size(), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
